// File: rtl/ff_apb_arbiter_pkg.sv
// Shared constants for the APB arbiter slice: FSM encodings, bus width defaults
// and the index-width helper used by the arbiter and its round-robin picker.
package ff_apb_arbiter_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A single requester still needs a 1-bit index so port widths never collapse to zero
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ff_apb_arbiter_if.sv
// APB bus between the arbiter (master) and the peripheral fabric (slave).
// FF_APB_ARBITER_PREADY_EN adds pready and the wait_cnt debug counter.
interface ff_apb_arbiter_if
    import ff_apb_arbiter_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
`ifdef FF_APB_ARBITER_PREADY_EN
    logic              pready;
    logic [7:0]        wait_cnt;

    modport master (
        output paddr, pwrite, psel, penable, pwdata, wait_cnt,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, wait_cnt,
        output prdata, pready
    );
`else
    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata
    );
`endif

endinterface

// File: rtl/ff_apb_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request found searching
// circularly from index start (the position just after the last grant).
module ff_rr_pick
    import ff_apb_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : pick
        int pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(start) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!any && req[pos] && !mask[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ff_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Define FF_APB_ARBITER_PREADY_EN to honour pready wait states and expose wait_cnt.
module ff_apb_arbiter
    import ff_apb_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_done,
    output logic [DATA_W-1:0]      req_rdata,
    ff_apb_arbiter_if.master       apb
);

    localparam int IDX_W = idx_w(NREQ);

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [NREQ-1:0]  grant_oh;
    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             pick_any;
    logic             xfer_done;
    logic             do_grant;

`ifdef FF_APB_ARBITER_PREADY_EN
    assign xfer_done = (state == ST_ACCESS) && apb.pready;
`else
    assign xfer_done = (state == ST_ACCESS);
`endif

    // The grantee stays masked through its completion edge and its done cycle,
    // so a requester still holding req while it reacts to req_done is not re-served.
    always_comb begin
        mask = '0;
        if ((state == ST_ACCESS) || (|req_done)) begin
            mask = grant_oh;
        end
    end

    ff_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (mask),
        .start (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign do_grant = pick_any && ((state == ST_IDLE) || xfer_done);
    assign next_ptr = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            grant_oh    <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            req_done    <= '0;
            req_rdata   <= '0;
`ifdef FF_APB_ARBITER_PREADY_EN
            apb.wait_cnt <= 8'd0;
`endif
        end else begin
            req_done <= '0;
            if (xfer_done) begin
                req_done <= grant_oh;
                if (!apb.pwrite) begin
                    req_rdata <= apb.prdata;
                end
            end

            case (state)
                ST_SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        state       <= ST_IDLE;
                    end
`ifdef FF_APB_ARBITER_PREADY_EN
                    else if (apb.wait_cnt != 8'hFF) begin
                        apb.wait_cnt <= apb.wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    apb.psel    <= 1'b0;
                    apb.penable <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase

            // A new grant from IDLE or straight out of a completing ACCESS overrides the above
            if (do_grant) begin
                state       <= ST_SETUP;
                apb.psel    <= 1'b1;
                apb.penable <= 1'b0;
                apb.paddr   <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                apb.pwrite  <= req_write[pick_idx];
                apb.pwdata  <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                grant_oh    <= pick_gnt;
                ptr         <= next_ptr;
`ifdef FF_APB_ARBITER_PREADY_EN
                apb.wait_cnt <= 8'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ff_apb_arbiter.sv
// Self-checking bench for ff_apb_arbiter: table-driven single transfers, hand sequences
// for contention/stale-req/reset/wait states, and a random run against a request-level model.
module tb_ff_apb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 32;

    logic               pclk = 1'b0;
    logic               preset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_done;
    logic [DW-1:0]      req_rdata;

    ff_apb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    ff_apb_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .apb       (apb)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] prd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input bit on, input bit wr, input logic [15:0] a,
                           input logic [31:0] d);
        req[i]               = on;
        req_write[i]         = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        req    = '0;
        step();
        step();
        preset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] e;
        e = '0;
        e[v.id] = 1'b1;
        set_req(v.id, 1'b1, v.wr, v.addr, v.wdata);
        apb.prdata = 32'h0;
        step();
        chk("vec_setup", {apb.psel, apb.penable}, 2'b10);
        chk("vec_paddr", apb.paddr, v.addr);
        chk("vec_pwrite", apb.pwrite, v.wr);
        if (v.wr) chk("vec_pwdata", apb.pwdata, v.wdata);
        apb.prdata = v.prd;
        step();
        chk("vec_access", {apb.psel, apb.penable}, 2'b11);
        chk("vec_paddr_hold", apb.paddr, v.addr);
        chk("vec_nodone", req_done, 0);
        step();
        chk("vec_done", req_done, e);
        chk("vec_rdata", req_rdata, v.exp_rd);
        chk("vec_idle", {apb.psel, apb.penable}, 2'b00);
        set_req(v.id, 1'b0, v.wr, v.addr, v.wdata);
        apb.prdata = 32'h5555_aaaa;
        step();
        chk("vec_done_clear", req_done, 0);
        chk("vec_stay_idle", apb.psel, 1'b0);
    endtask

    initial begin : main
        logic [15:0]     c_addr[4];
        logic [NREQ-1:0] c_done[4];
        bit              dropnext;
        int              setups;
        int              dones;
        // random-run state
        bit              act[NREQ];
        bit              drop_nx[NREQ];
        bit              w_r[NREQ];
        logic [15:0]     a_r[NREQ];
        logic [31:0]     d_r[NREQ];
        int              age[NREQ];
        logic            p_psel, p_pen, p_pwrite, p_rdy, p_done_any;
        logic [15:0]     p_paddr;
        logic [31:0]     p_pwdata, p_prdata, exp_rdata;
        logic [NREQ-1:0] exp_done, elig;
        int              last_gnt, found, cand, id, issued, completed;
        bit              comp_now, busy, abort;

        tbl[0] = '{0, 1'b1, 16'h0010, 32'hdeadbeef, 32'h0bad0bad, 32'h0};
        tbl[1] = '{1, 1'b0, 16'h0020, 32'h0,        32'h12345678, 32'h12345678};
        tbl[2] = '{0, 1'b0, 16'h0100, 32'h0,        32'hcafef00d, 32'hcafef00d};
        tbl[3] = '{1, 1'b1, 16'h0200, 32'h0,        32'hffffffff, 32'hcafef00d};
        tbl[4] = '{1, 1'b0, 16'hffff, 32'h0,        32'h0,        32'h0};
        tbl[5] = '{0, 1'b1, 16'h0000, 32'hffffffff, 32'ha5a5a5a5, 32'h0};

        apb.prdata = '0;
`ifdef FF_APB_ARBITER_PREADY_EN
        apb.pready = 1'b1;
`endif

        // reset values
        do_reset();
        chk("rst_psel", apb.psel, 1'b0);
        chk("rst_penable", apb.penable, 1'b0);
        chk("rst_pwrite", apb.pwrite, 1'b0);
        chk("rst_paddr", apb.paddr, 0);
        chk("rst_pwdata", apb.pwdata, 0);
        chk("rst_done", req_done, 0);
        chk("rst_rdata", req_rdata, 0);
`ifdef FF_APB_ARBITER_PREADY_EN
        chk("rst_wait_cnt", apb.wait_cnt, 0);
`endif

        // contention: both requesters held, grants alternate 0,1,0,1 with psel never dropping
        c_addr = '{16'h0a00, 16'h1b00, 16'h0a00, 16'h1b00};
        c_done = '{2'b00, 2'b01, 2'b10, 2'b01};
        set_req(0, 1'b1, 1'b0, 16'h0a00, 32'h0);
        set_req(1, 1'b1, 1'b0, 16'h1b00, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("cont_psel", apb.psel, 1'b1);
            if (k % 2 == 1) begin
                chk("cont_setup_pen", apb.penable, 1'b0);
                chk("cont_grant_addr", apb.paddr, c_addr[(k-1)/2]);
                chk("cont_done", req_done, c_done[(k-1)/2]);
            end else begin
                chk("cont_access_pen", apb.penable, 1'b1);
            end
            if (k == 8) req = '0;
        end
        step();
        chk("cont_last_done", req_done, 2'b10);
        chk("cont_idle", apb.psel, 1'b0);

        // table of single transfers
        do_reset();
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // stale req: held through its done cycle, dropped after, must yield one transfer
        setups = 0;
        dones = 0;
        dropnext = 1'b0;
        set_req(0, 1'b1, 1'b1, 16'h0300, 32'h01020304);
        for (int k = 0; k < 8; k++) begin
            step();
            if (apb.psel && !apb.penable) setups++;
            if (req_done[0]) dones++;
            if (dropnext) req[0] = 1'b0;
            if (req_done[0]) dropnext = 1'b1;
        end
        chk("stale_setups", setups, 1);
        chk("stale_dones", dones, 1);

        // reset during ACCESS: transfer lost, no done
        set_req(1, 1'b1, 1'b0, 16'h0400, 32'h0);
        apb.prdata = 32'h77777777;
        step();
        step();
        chk("rstmid_in_access", {apb.psel, apb.penable}, 2'b11);
        preset = 1'b1;
        step();
        chk("rstmid_bus", {apb.psel, apb.penable}, 2'b00);
        chk("rstmid_done", req_done, 0);
        preset = 1'b0;
        req = '0;
        step();
        chk("rstmid_done_after", req_done, 0);
        chk("rstmid_rdata", req_rdata, 0);

`ifdef FF_APB_ARBITER_PREADY_EN
        // three wait states: ACCESS for 4 cycles, done on the pready edge
        set_req(0, 1'b1, 1'b0, 16'h0500, 32'h0);
        step();
        apb.pready = 1'b0;
        apb.prdata = 32'h89abcdef;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wait_access", {apb.psel, apb.penable}, 2'b11);
            chk("wait_nodone", req_done, 0);
        end
        apb.pready = 1'b1;
        step();
        chk("wait_done", req_done, 2'b01);
        chk("wait_rdata", req_rdata, 32'h89abcdef);
        chk("wait_cnt", apb.wait_cnt, 8'd3);
        req = '0;
        step();
`endif

        // randomized traffic against a request-level model
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 1'b0; drop_nx[i] = 1'b0; w_r[i] = 1'b0;
            a_r[i] = '0; d_r[i] = '0; age[i] = 0;
        end
        p_psel = 1'b0; p_pen = 1'b0; p_pwrite = 1'b0; p_rdy = 1'b1; p_done_any = 1'b0;
        p_paddr = '0; p_pwdata = '0; p_prdata = '0;
        exp_rdata = '0;
        last_gnt = NREQ - 1;
        issued = 0;
        completed = 0;
        abort = 1'b0;
        for (int it = 0; it < 3400 && !abort; it++) begin
            busy = 1'b0;
            for (int i = 0; i < NREQ; i++) busy = busy | act[i];
            if (it >= 3000 && !busy) break;
            step();

            comp_now = p_psel && p_pen && p_rdy;
            exp_done = '0;
            if (comp_now) begin
                id = int'(p_paddr[15:12]);
                chk("rnd_owner", (id < NREQ) ? act[id] : 1'b0, 1'b1);
                if (id < NREQ) begin
                    chk("rnd_xfer_addr", p_paddr, a_r[id]);
                    chk("rnd_xfer_dir", p_pwrite, w_r[id]);
                    if (w_r[id]) chk("rnd_xfer_wdata", p_pwdata, d_r[id]);
                    exp_done[id] = 1'b1;
                    if (!w_r[id]) exp_rdata = p_prdata;
                end
                completed++;
            end
            chk("rnd_done", req_done, exp_done);
            chk("rnd_rdata", req_rdata, exp_rdata);

            if (!p_psel || comp_now) begin
                elig = req;
                if (comp_now || p_done_any) elig[last_gnt] = 1'b0;
                found = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    cand = (last_gnt + k) % NREQ;
                    if (found < 0 && elig[cand]) found = cand;
                end
                if (found >= 0) begin
                    chk("rnd_setup", {apb.psel, apb.penable}, 2'b10);
                    chk("rnd_grant", apb.paddr[15:12], found);
                    chk("rnd_grant_dir", apb.pwrite, w_r[found]);
                    last_gnt = found;
                end else begin
                    chk("rnd_idle", {apb.psel, apb.penable}, 2'b00);
                end
            end else begin
                chk("rnd_busy", {apb.psel, apb.penable}, 2'b11);
                chk("rnd_addr_stable", apb.paddr, p_paddr);
                chk("rnd_dir_stable", apb.pwrite, p_pwrite);
            end

            for (int i = 0; i < NREQ; i++) begin
                if (drop_nx[i]) begin
                    act[i] = 1'b0;
                    drop_nx[i] = 1'b0;
                end else if (act[i] && req_done[i]) begin
                    drop_nx[i] = 1'b1;
                end else if (!act[i] && it < 3000 && $urandom_range(2) == 0) begin
                    act[i] = 1'b1;
                    w_r[i] = 1'($urandom_range(1));
                    a_r[i] = {4'(i), 12'($urandom)};
                    d_r[i] = $urandom;
                    age[i] = 0;
                    issued++;
                end
                if (act[i] && !drop_nx[i]) begin
                    age[i]++;
                    if (age[i] > 400) begin
                        chk("rnd_timeout", age[i], 400);
                        abort = 1'b1;
                    end
                end
                set_req(i, act[i], w_r[i], a_r[i], d_r[i]);
            end
            apb.prdata = $urandom;
`ifdef FF_APB_ARBITER_PREADY_EN
            apb.pready = ($urandom_range(3) != 0);
            p_rdy = apb.pready;
`endif
            p_psel = apb.psel;
            p_pen = apb.penable;
            p_pwrite = apb.pwrite;
            p_paddr = apb.paddr;
            p_pwdata = apb.pwdata;
            p_prdata = apb.prdata;
            p_done_any = |req_done;
        end
        chk("rnd_all_completed", completed, issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
